// File: rtl/decode_prefix_buf.sv
`default_nettype none
// ============================================================================
// Module   : decode_prefix_buf
// Brief    : Byte-serial front end; strips legacy prefixes / 0x0F escape into
//            flags and packs body bytes into a 72-bit window for decode.
// Revision : 1.0 - initial release
// ============================================================================
module decode_prefix_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [71:0] unescaped_instr,
    output logic        escaped,
    output logic        prefix_operand_16bit,
    output logic        prefix_address_16bit,
    output logic        prefix_lock,
    output logic        prefix_rep,
    output logic        prefix_repne,
    output logic [3:0]  instr_len,
    output logic        instr_err
);
    localparam logic [1:0] S_PREFIX = 2'd0;
    localparam logic [1:0] S_BODY   = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [3:0] C_SLOTS   = 4'd9;
    localparam logic [3:0] C_LEN_MAX = 4'd15;

    logic [1:0]  r_state;
    logic        r_byte_ready;
    logic        r_instr_valid;
    logic [71:0] r_window;
    logic [3:0]  r_idx;
    logic [3:0]  r_len;
    logic        r_err;
    logic        r_escaped;
    logic        r_op16;
    logic        r_addr16;
    logic        r_lock;
    logic        r_rep;
    logic        r_repne;

    logic        w_accept;
    logic        w_in_prefix;
    logic        w_flag_prefix;
    logic        w_seg_prefix;
    logic        w_escape;
    logic        w_body;
    logic        w_store;
    logic        w_overflow;
    logic        w_len_err;
    logic        w_empty_err;
    logic [3:0]  w_idx_next;

    assign w_accept    = byte_valid && r_byte_ready;
    assign w_in_prefix = (r_state == S_PREFIX);

    always_comb begin
        w_flag_prefix = 1'b0;
        w_seg_prefix  = 1'b0;
        case (byte_in)
            8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3:       w_flag_prefix = 1'b1;
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: w_seg_prefix  = 1'b1;
            default: ;
        endcase
    end

    // Prefix and escape decoding only applies before the first body byte.
    assign w_escape    = w_in_prefix && (byte_in == 8'h0F);
    assign w_body      = !(w_in_prefix && (w_flag_prefix || w_seg_prefix)) && !w_escape;
    assign w_store     = w_accept && w_body && (r_idx < C_SLOTS);
    assign w_overflow  = w_accept && w_body && (r_idx == C_SLOTS);
    assign w_idx_next  = w_store ? (r_idx + 4'd1) : r_idx;
    assign w_len_err   = w_accept && (r_len == C_LEN_MAX) && !byte_last;
    assign w_empty_err = w_accept && byte_last && (w_idx_next == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_PREFIX;
            r_byte_ready  <= 1'b1;
            r_instr_valid <= 1'b0;
            r_window      <= '0;
            r_idx         <= '0;
            r_len         <= '0;
            r_err         <= 1'b0;
            r_escaped     <= 1'b0;
            r_op16        <= 1'b0;
            r_addr16      <= 1'b0;
            r_lock        <= 1'b0;
            r_rep         <= 1'b0;
            r_repne       <= 1'b0;
        end else if (r_state == S_HOLD) begin
            if (instr_ready) begin
                r_state       <= S_PREFIX;
                r_byte_ready  <= 1'b1;
                r_instr_valid <= 1'b0;
                r_window      <= '0;
                r_idx         <= '0;
                r_len         <= '0;
                r_err         <= 1'b0;
                r_escaped     <= 1'b0;
                r_op16        <= 1'b0;
                r_addr16      <= 1'b0;
                r_lock        <= 1'b0;
                r_rep         <= 1'b0;
                r_repne       <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_len != C_LEN_MAX) begin
                r_len <= r_len + 4'd1;
            end
            if (w_in_prefix) begin
                case (byte_in)
                    8'h66: r_op16   <= 1'b1;
                    8'h67: r_addr16 <= 1'b1;
                    8'hF0: r_lock   <= 1'b1;
                    8'hF2: begin r_repne <= 1'b1; r_rep <= 1'b0; end
                    8'hF3: begin r_rep   <= 1'b1; r_repne <= 1'b0; end
                    8'h0F: r_escaped <= 1'b1;
                    default: ;
                endcase
            end
            for (int k = 0; k < 9; k++) begin
                if (w_store && (r_idx == 4'(k))) begin
                    r_window[8*k +: 8] <= byte_in;
                end
            end
            r_idx <= w_idx_next;
            if (w_overflow || w_len_err || w_empty_err) begin
                r_err <= 1'b1;
            end
            if (byte_last) begin
                r_state       <= S_HOLD;
                r_byte_ready  <= 1'b0;
                r_instr_valid <= 1'b1;
            end else if (w_in_prefix && (w_escape || w_body)) begin
                r_state <= S_BODY;
            end
        end
    end

    assign byte_ready           = r_byte_ready;
    assign instr_valid          = r_instr_valid;
    assign unescaped_instr      = r_window;
    assign escaped              = r_escaped;
    assign prefix_operand_16bit = r_op16;
    assign prefix_address_16bit = r_addr16;
    assign prefix_lock          = r_lock;
    assign prefix_rep           = r_rep;
    assign prefix_repne         = r_repne;
    assign instr_len            = r_len;
    assign instr_err            = r_err;
endmodule
`default_nettype wire

// File: doc/decode_prefix_buf.md
# decode_prefix_buf

Byte-serial instruction front end sitting directly upstream of operand decode. It accepts one instruction byte per cycle from the fetch/witness stream, strips legacy prefixes and the 0x0F escape, and records them as flags. It packs the remaining opcode/ModR/M/SIB/disp/imm bytes into the 72-bit `unescaped_instr` window. It then presents the assembled instruction over a valid/ready handshake.

## Interface
- No parameters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `byte_in`  in  8  next instruction byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_last`  in  1  qualifies `byte_in` as the final byte of the instruction.
- `byte_ready`  out  1  block accepts a byte this cycle.
- `instr_valid`  out  1  assembled instruction is available.
- `instr_ready`  in  1  downstream consumes the instruction.
- `unescaped_instr`  out  72  post-prefix, post-escape bytes; byte k at [8k+7:8k]; opcode at [7:0]; unused bytes 0.
- `escaped`  out  1  a 0x0F escape preceded the opcode.
- `prefix_operand_16bit`  out  1  0x66 seen.
- `prefix_address_16bit`  out  1  0x67 seen.
- `prefix_lock`  out  1  0xF0 seen.
- `prefix_rep`  out  1  0xF3 was the last F2/F3 seen.
- `prefix_repne`  out  1  0xF2 was the last F2/F3 seen.
- `instr_len`  out  4  total accepted bytes, including prefixes and escape, saturating at 15.
- `instr_err`  out  1  malformed instruction; see Operation.

## Operation
- The FSM has three states: `S_PREFIX` (reset state), `S_BODY`, and `S_HOLD`.
- A byte is accepted when `byte_valid && byte_ready`. `byte_ready` = (state != `S_HOLD`).
- **S_PREFIX:**
  - 0x66, 0x67, 0xF0, 0xF2, and 0xF3 set their flag. F2 and F3 are mutually exclusive; the last one seen wins.
  - Segment prefixes 0x26, 0x2E, 0x36, 0x3E, 0x64, and 0x65 are accepted and discarded.
  - Duplicate prefixes are idempotent.
  - 0x0F sets `escaped`. The state moves to `S_BODY` without storing the byte.
  - Any other byte is stored as byte 0, and the state moves to `S_BODY`.
- **S_BODY:** every byte is stored at the next free slot, including values that look like prefixes or 0x0F. After an escape, the first stored byte is the opcode.
- Store index runs 0..8. A 10th body byte sets `instr_err` and is dropped; later bytes are dropped as well.
- `instr_len` counts every accepted byte. If a byte accepted while the count is already 15 is not `byte_last`, `instr_err` is set. Bytes keep being accepted and dropped until `byte_last`.
- On an accepted byte with `byte_last`, the state moves to `S_HOLD` from any state. If no byte has been stored (only prefixes and/or escape), `instr_err` is set and `unescaped_instr` = 0.
- **S_HOLD:** `instr_valid` = 1 and all outputs are held stable. When `instr_ready` = 1:
  - the state moves to `S_PREFIX`;
  - all flags, the window, `instr_len`, and `instr_err` clear to 0 on the next edge.
- `instr_err` is informational. The instruction is still emitted and must still be consumed.

## Timing
- On `rst` assertion, regardless of clock: state = `S_PREFIX` and all outputs are 0, except `byte_ready` = 1. Any in-flight instruction is discarded.
- All outputs are registered. No combinational path from `byte_*` to `instr_*` or from `instr_ready` to `byte_ready`.
- `instr_valid` rises on the edge that accepts the `byte_last` byte, so it is visible the cycle after.
- `byte_ready` is 0 for the whole of `S_HOLD`, including the cycle in which `instr_ready` = 1. The next instruction's first byte is accepted no earlier than the following cycle.
- Throughput is one instruction per (N + 1) cycles for N bytes with back-to-back traffic.
- A `byte_valid` gap in any state stalls with no state change. `byte_last` is ignored unless `byte_valid && byte_ready`.
- `instr_ready` asserted while `instr_valid` = 0 has no effect.

## Test plan
- **Plain ADD.** Stream 01 C8 with `byte_last` on C8, `instr_ready` = 1.
  - `instr_valid` is high one cycle after C8 and stays high exactly one cycle.
  - `unescaped_instr` = 0x...00C801, all flags 0, `instr_len` = 2.
  - `byte_ready` is 0 in that cycle.
- **Prefixes and escape.** Stream 66 67 F2 F3 0F AF C1.
  - `unescaped_instr[15:0]` = 0xC1AF.
  - `escaped` = 1, `prefix_operand_16bit` = 1, `prefix_address_16bit` = 1, `prefix_rep` = 1, `prefix_repne` = 0, `instr_len` = 7.
- **Backpressure and stalls.** Hold `instr_ready` = 0 for 5 cycles with another instruction pending upstream, and insert `byte_valid` gaps mid-instruction.
  - Outputs stay stable and `byte_ready` stays 0 until the handshake.
  - After the handshake, the next instruction assembles from clean state.
- **Window overflow and length limit.**
  - Stream C7 84 24 + 8 more bytes, 11 body bytes in total: only the first 9 are stored, `instr_err` = 1, `instr_len` = 11.
  - Stream 16 bytes of 90 ending in `byte_last`: `instr_err` = 1, `instr_len` = 15.
- **Prefix-only instruction.** Stream 66 0F with `byte_last` on 0F.
  - `instr_err` = 1, `unescaped_instr` = 0, `escaped` = 1, `instr_len` = 2.
- **Reset.** Assert `rst` asynchronously mid-instruction, for example after 66 0F.
  - All outputs read 0 immediately and `byte_ready` = 1.
  - The next stream, 90 with `byte_last`, yields `unescaped_instr` = 0x90, no flags.
